start_sync_fifo_mc: RTL and testbench

//  Multi-channel start-token FIFO for dataflow process start synchronisation; successor to the single-channel start SRL.
//  NUM_CH SRL-based FIFOs with full/empty handshakes, occupancy counts and almost-full flags.

---
 rtl/start_fifo_pkg.sv | 21 ++
 rtl/start_fifo_srl_core.sv | 61 ++++++
 rtl/start_sync_fifo_mc.sv | 77 +++++++
 tb/tb_start_sync_fifo_mc.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/start_fifo_pkg.sv
// Shared constants and helpers for the multi-channel start-token FIFO.
package start_fifo_pkg;

  localparam int MODE_INDEPENDENT = 0;
  localparam int MODE_BROADCAST   = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Occupancy needs one bit more than the address so count==DEPTH is representable.
  function automatic int cnt_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  localparam int DEF_CNT_W = cnt_w(2);

endpackage

// File: rtl/start_fifo_srl_core.sv
// One SRL start-token FIFO: shift-in storage, occupancy count and registered handshake flags.
module start_fifo_srl_core
  import start_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 1,
  parameter int AF_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop_en,
  output logic                  full_n,
  output logic                  empty_n,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int CW = ADDR_WIDTH + 1;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] srl;
  logic [CW-1:0]                    cnt_nxt;
  logic [ADDR_WIDTH-1:0]            head_idx;
  logic                             wr_acc, pop_acc;

  assign wr_acc   = write && full_n;
  assign pop_acc  = pop_en && empty_n;
  assign head_idx = ADDR_WIDTH'(count - 1'b1);
  assign dout     = srl[head_idx];

  // Storage is deliberately unreset; empty_n guards any stale contents.
  always_ff @(posedge clk) begin
    if (wr_acc) srl <= {srl[DEPTH-2:0], din};
  end

  always_comb begin
    cnt_nxt = count;
    if (wr_acc && !pop_acc)      cnt_nxt = count + 1'b1;
    else if (!wr_acc && pop_acc) cnt_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      full_n      <= 1'b1;
      empty_n     <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      count       <= cnt_nxt;
      full_n      <= (cnt_nxt != CW'(DEPTH));
      empty_n     <= (cnt_nxt != '0);
      almost_full <= (cnt_nxt >= CW'(DEPTH - AF_LEVEL));
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) count <= CW'(DEPTH));

endmodule

// File: rtl/start_sync_fifo_mc.sv
// Multi-channel start-token FIFO: independent per-channel SRLs, or one shared SRL broadcast to all consumers.
module start_sync_fifo_mc
  import start_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 1,
  parameter int NUM_CH     = 4,
  parameter int MODE       = 0,
  parameter int AF_LEVEL   = 1
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst_n,
  input  logic [NUM_CH-1:0]              if_write,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   if_din,
  output logic [NUM_CH-1:0]              if_full_n,
  input  logic [NUM_CH-1:0]              if_read,
  output logic [NUM_CH*DATA_WIDTH-1:0]   if_dout,
  output logic [NUM_CH-1:0]              if_empty_n,
  output logic [NUM_CH-1:0]              almost_full,
  output logic [NUM_CH*(ADDR_WIDTH+1)-1:0] count
);

  localparam int CW = ADDR_WIDTH + 1;

  a_addr_fits: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) CW >= cnt_w(DEPTH));

  if (MODE == MODE_BROADCAST) begin : g_bcast
    logic                  sh_full_n, sh_empty_n, sh_af, pop_all;
    logic [CW-1:0]         sh_cnt;
    logic [DATA_WIDTH-1:0] sh_dout;
    logic [NUM_CH-1:0]     taken, rd_acc, seen;

    start_fifo_srl_core #(
      .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .AF_LEVEL(AF_LEVEL)
    ) u_core (
      .clk(ap_clk), .rst_n(ap_rst_n),
      .write(if_write[0]), .din(if_din[DATA_WIDTH-1:0]), .pop_en(pop_all),
      .full_n(sh_full_n), .empty_n(sh_empty_n), .almost_full(sh_af),
      .count(sh_cnt), .dout(sh_dout)
    );

    // A consumer that already took the head is held empty until every consumer has it.
    assign if_empty_n = {NUM_CH{sh_empty_n}} & ~taken;
    assign rd_acc     = if_read & if_empty_n;
    assign seen       = taken | rd_acc;
    assign pop_all    = &seen;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)    taken <= '0;
      else if (pop_all) taken <= '0;
      else              taken <= seen;
    end

    assign if_full_n   = {NUM_CH{sh_full_n}};
    assign almost_full = {NUM_CH{sh_af}};
    assign count       = {NUM_CH{sh_cnt}};
    assign if_dout     = {NUM_CH{sh_dout}};

    if (NUM_CH > 1) begin : g_unused
      logic unused_wr;
      assign unused_wr = ^{if_write[NUM_CH-1:1], if_din[NUM_CH*DATA_WIDTH-1:DATA_WIDTH]};
    end
  end else begin : g_indep
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      start_fifo_srl_core #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_WIDTH(ADDR_WIDTH), .AF_LEVEL(AF_LEVEL)
      ) u_core (
        .clk(ap_clk), .rst_n(ap_rst_n),
        .write(if_write[c]), .din(if_din[c*DATA_WIDTH +: DATA_WIDTH]), .pop_en(if_read[c]),
        .full_n(if_full_n[c]), .empty_n(if_empty_n[c]), .almost_full(almost_full[c]),
        .count(count[c*CW +: CW]), .dout(if_dout[c*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  end

endmodule

// File: tb/tb_start_sync_fifo_mc.sv
// Directed scoreboard bench: one independent-mode and one broadcast-mode instance of the start FIFO.
module tb_start_sync_fifo_mc;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0] i_write = '0, i_din = '0, i_read = '0;
  logic [NCH-1:0] i_full_n, i_dout, i_empty_n, i_af;
  logic [2*NCH-1:0] i_count;
  logic [NCH-1:0] b_write = '0, b_din = '0, b_read = '0;
  logic [NCH-1:0] b_full_n, b_dout, b_empty_n, b_af;
  logic [2*NCH-1:0] b_count;

  start_sync_fifo_mc #(.DATA_WIDTH(1), .DEPTH(2), .ADDR_WIDTH(1), .NUM_CH(NCH), .MODE(0), .AF_LEVEL(1)) u_ind (
    .ap_clk(clk), .ap_rst_n(rst_n), .if_write(i_write), .if_din(i_din), .if_full_n(i_full_n),
    .if_read(i_read), .if_dout(i_dout), .if_empty_n(i_empty_n), .almost_full(i_af), .count(i_count));

  start_sync_fifo_mc #(.DATA_WIDTH(1), .DEPTH(2), .ADDR_WIDTH(1), .NUM_CH(NCH), .MODE(1), .AF_LEVEL(1)) u_bc (
    .ap_clk(clk), .ap_rst_n(rst_n), .if_write(b_write), .if_din(b_din), .if_full_n(b_full_n),
    .if_read(b_read), .if_dout(b_dout), .if_empty_n(b_empty_n), .almost_full(b_af), .count(b_count));

  int vectors = 0;
  int miscompares = 0;
  logic iq [NCH][$];
  logic bq [NCH][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: every accepted read is checked against the next expected token for that channel.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (i_read[c] && i_empty_n[c]) begin
        vectors++;
        if (iq[c].size() == 0) begin
          miscompares++;
          $display("FAIL ind_read ch%0d: unexpected read accepted, dout %0b", c, i_dout[c]);
        end else begin
          logic e;
          e = iq[c].pop_front();
          if (i_dout[c] !== e) begin
            miscompares++;
            $display("FAIL ind_read ch%0d: got %0b expected %0b", c, i_dout[c], e);
          end
        end
      end
      if (b_read[c] && b_empty_n[c]) begin
        vectors++;
        if (bq[c].size() == 0) begin
          miscompares++;
          $display("FAIL bc_read ch%0d: unexpected read accepted, dout %0b", c, b_dout[c]);
        end else begin
          logic e;
          e = bq[c].pop_front();
          if (b_dout[c] !== e) begin
            miscompares++;
            $display("FAIL bc_read ch%0d: got %0b expected %0b", c, b_dout[c], e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_write = '0; i_din = '0; i_read = '0;
    b_write = '0; b_din = '0; b_read = '0;
  endtask

  logic [8:0] tk = 9'b1_0101_1001;
  logic [3:0] order [4] = '{4'd2, 4'd0, 4'd3, 4'd1};
  logic [3:0] exp_en;

  initial begin
    // Reset held with writes asserted
    i_write = '1; i_din = '1; b_write = '1; b_din = '1;
    step(); step();
    chk("rst_i_full_n", i_full_n, 4'hF);
    chk("rst_i_empty_n", i_empty_n, 4'h0);
    chk("rst_i_count", i_count, 8'h00);
    chk("rst_i_af", i_af, 4'h0);
    chk("rst_b_empty_n", b_empty_n, 4'h0);
    chk("rst_b_count", b_count, 8'h00);
    idle(); rst_n = 1'b1;
    step(); step();
    chk("post_rst_i_count", i_count, 8'h00);
    chk("post_rst_b_empty_n", b_empty_n, 4'h0);

    // Independent: two writes on ch2 fill it, third ignored
    i_write = 4'b0100; i_din = 4'b0100; step();
    i_din = 4'b0000; step();
    idle();
    chk("ch2_count2", i_count, 8'b00_10_00_00);
    chk("ch2_full_n", i_full_n, 4'b1011);
    chk("ch2_af", i_af, 4'b0100);
    chk("ch2_empty_n", i_empty_n, 4'b0100);
    i_write = 4'b0100; i_din = 4'b0100; step(); idle();
    chk("ch2_third_ignored", i_count, 8'b00_10_00_00);
    iq[2].push_back(1'b1); iq[2].push_back(1'b0);
    i_read = 4'b0100; step(); step(); idle();
    chk("ch2_drained", i_count, 8'h00);
    chk("ch2_empty", i_empty_n, 4'h0);

    // Independent: streaming write+read on ch0 keeps count at 1
    i_write = 4'b0001; i_din = {3'b0, tk[0]}; step();
    for (int k = 0; k < 8; k++) begin
      iq[0].push_back(tk[k]);
      i_write = 4'b0001; i_din = {3'b0, tk[k+1]}; i_read = 4'b0001;
      step();
      chk($sformatf("stream_count_%0d", k), i_count, 8'b00_00_00_01);
    end
    idle();
    iq[0].push_back(tk[8]);
    i_read = 4'b0001; step(); idle();
    chk("stream_drained", i_count, 8'h00);

    // Independent: full + write/read rejects the write; empty + write/read accepts it
    i_write = 4'b0010; i_din = 4'b0010; step();
    i_din = 4'b0000; step(); idle();
    chk("ch1_full", i_full_n, 4'b1101);
    iq[1].push_back(1'b1);
    i_write = 4'b0010; i_din = 4'b0010; i_read = 4'b0010; step(); idle();
    chk("full_wr_rd_count", i_count, 8'b00_00_01_00);
    chk("full_wr_rd_full_n", i_full_n, 4'hF);
    iq[1].push_back(1'b0);
    i_read = 4'b0010; step(); idle();
    chk("ch1_empty", i_count, 8'h00);
    i_write = 4'b0010; i_din = 4'b0010; i_read = 4'b0010; step(); idle();
    chk("empty_wr_rd_count", i_count, 8'b00_00_01_00);
    chk("empty_wr_rd_empty_n", i_empty_n, 4'b0010);
    iq[1].push_back(1'b1);
    i_read = 4'b0010; step(); idle();
    chk("ch1_final", i_count, 8'h00);

    // Broadcast: one token read by consumers 2,0,3,1
    b_write = 4'b0001; b_din = 4'b0001; step(); idle();
    chk("bc_count1", b_count, 8'h55);
    chk("bc_empty_n_all", b_empty_n, 4'hF);
    exp_en = 4'hF;
    for (int k = 0; k < 4; k++) begin
      bq[order[k]].push_back(1'b1);
      b_read = 4'b0001 << order[k]; step(); idle();
      exp_en[order[k]] = 1'b0;
      if (k < 3) begin
        chk($sformatf("bc_empty_n_%0d", k), b_empty_n, exp_en);
        chk($sformatf("bc_hold_%0d", k), b_count, 8'h55);
      end
    end
    chk("bc_popped_count", b_count, 8'h00);
    chk("bc_popped_empty", b_empty_n, 4'h0);

    // Broadcast: all read together, next head becomes visible to everyone
    b_write = 4'b0001; b_din = 4'b0001; step();
    b_din = 4'b0000; step(); idle();
    chk("bc_count2", b_count, 8'hAA);
    chk("bc_full", b_full_n, 4'h0);
    for (int c = 0; c < NCH; c++) bq[c].push_back(1'b1);
    b_read = 4'hF; step(); idle();
    chk("bc_next_head_count", b_count, 8'h55);
    chk("bc_next_head_en", b_empty_n, 4'hF);
    for (int c = 0; c < NCH; c++) bq[c].push_back(1'b0);
    b_read = 4'hF; step(); idle();
    chk("bc_drained", b_count, 8'h00);

    // Broadcast: reset mid-operation with taken=0101, count=2
    b_write = 4'b0001; b_din = 4'b0001; step();
    b_din = 4'b0000; step(); idle();
    bq[0].push_back(1'b1); bq[2].push_back(1'b1);
    b_read = 4'b0101; step(); idle();
    chk("bc_taken_en", b_empty_n, 4'b1010);
    chk("bc_taken_count", b_count, 8'hAA);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_empty_n", b_empty_n, 4'h0);
    chk("async_rst_count", b_count, 8'h00);
    chk("async_rst_full_n", b_full_n, 4'hF);
    chk("async_rst_af", b_af, 4'h0);
    step();
    rst_n = 1'b1;
    step();
    chk("rel_empty_n", b_empty_n, 4'h0);
    b_write = 4'b0001; b_din = 4'b0001; step(); idle();
    chk("rel_mask_cleared", b_empty_n, 4'hF);

    step(); step();
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("ind_queue_left_ch%0d", c), iq[c].size(), 0);
      chk($sformatf("bc_queue_left_ch%0d", c), bq[c].size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
